alif_neuron_core: RTL and testbench

Single-channel adaptive leaky integrate-and-fire (ALIF) neuron core. Consumes the parameter set produced by the serial parameter loader (`weight_a`, `leak_rate`, `threshold_min`, `leak_cycles`, `params_ready`) and a per-cycle input current. It integrates the weighted input into a saturating 8-bit membrane potential, applies periodic leak, and raises an adaptive threshold after each spike. It emits one-cycle output spikes, followed by a fixed refractory period.

---
 rtl/alif_pkg.sv | 29 ++
 rtl/alif_leak_timer.sv | 55 +++++
 rtl/alif_neuron_core.sv | 156 +++++++++++++++
 tb/tb_alif_neuron_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alif_pkg.sv
// ---------------------------------------------------------------------------
// alif_pkg
// Shared definitions for the ALIF neuron core and its serial parameter loader:
// FSM state encoding, datapath widths, loader default parameter values and a
// saturating narrowing helper used by the membrane/threshold datapath.
// ---------------------------------------------------------------------------
package alif_pkg;

    typedef enum logic [1:0] {
        WAIT_PARAMS = 2'd0,
        INTEGRATE   = 2'd1,
        REFRACTORY  = 2'd2
    } alif_state_e;

    localparam int MEM_W = 8;
    localparam int CUR_W = 8;

    // Power-up values the loader presents before any serial write.
    localparam logic [2:0]       DEF_WEIGHT      = 3'd2;
    localparam logic [MEM_W-1:0] DEF_LEAK_RATE   = 8'd2;
    localparam logic [MEM_W-1:0] DEF_THR_MIN     = 8'd30;
    localparam logic [3:0]       DEF_LEAK_CYCLES = 4'd2;

    // Clamp a 12-bit unsigned intermediate to the 8-bit range.
    function automatic logic [MEM_W-1:0] sat_u8(input logic [11:0] v);
        return (v > 12'd255) ? 8'hFF : v[MEM_W-1:0];
    endfunction

endpackage

// File: rtl/alif_leak_timer.sv
// ---------------------------------------------------------------------------
// alif_leak_timer
// Free-running 4-bit leak counter. While run_i is high it counts enabled
// cycles and asserts leak_event_o on the cycle where counter+1 reaches
// leak_cycles_i, wrapping to 0 on that edge. leak_cycles_i == 0 disables
// leak events and pins the counter at 0.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   run_i          advance the counter this cycle
//   clear_i        synchronous clear (core parked without parameters)
//   leak_cycles_i  leak period in enabled cycles
//   leak_event_o   combinational leak-event strobe for the current cycle
// ---------------------------------------------------------------------------
module alif_leak_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       clear_i,
    input  logic [3:0] leak_cycles_i,
    output logic       leak_event_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [4:0] cnt_inc;
    logic       hit;

    // 5-bit increment so a live reduction of leak_cycles below the current
    // count wraps cleanly instead of aliasing.
    assign cnt_inc      = {1'b0, cnt_q} + 5'd1;
    assign hit          = (leak_cycles_i != 4'd0) && (cnt_inc == {1'b0, leak_cycles_i});
    assign leak_event_o = run_i && !clear_i && hit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 4'd0;
        end else if (run_i) begin
            if (leak_cycles_i == 4'd0 || hit) begin
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_inc[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alif_neuron_core.sv
// ---------------------------------------------------------------------------
// alif_neuron_core
// Single-channel adaptive leaky integrate-and-fire neuron. Integrates the
// weighted input current into a saturating 8-bit membrane, applies periodic
// leak, fires a one-cycle spike when the membrane reaches the adaptive
// threshold, raises the threshold by THR_INC per spike and lets it decay back
// towards threshold_min on leak events. Each spike is followed by a
// REFRAC_CYCLES-long refractory period during which input is ignored.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         global advance; low freezes state (spike_out still clears)
//   params_ready   loader parameters valid; low parks the core in WAIT_PARAMS
//   weight_a, leak_rate, threshold_min, leak_cycles   live neuron parameters
//   input_current, input_valid                          input sample
//   spike_out      registered spike pulse
//   membrane       membrane potential
//   threshold      adaptive threshold
//   refractory     high while in REFRACTORY
// ---------------------------------------------------------------------------
module alif_neuron_core
    import alif_pkg::*;
#(
    parameter logic [7:0] THR_INC       = 8'd10,
    parameter logic [3:0] REFRAC_CYCLES = 4'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             params_ready,
    input  logic [2:0]       weight_a,
    input  logic [MEM_W-1:0] leak_rate,
    input  logic [MEM_W-1:0] threshold_min,
    input  logic [3:0]       leak_cycles,
    input  logic [CUR_W-1:0] input_current,
    input  logic             input_valid,
    output logic             spike_out,
    output logic [MEM_W-1:0] membrane,
    output logic [MEM_W-1:0] threshold,
    output logic             refractory
);

    alif_state_e      state_q, state_d;
    logic [MEM_W-1:0] mem_q, mem_d;
    logic [MEM_W-1:0] thr_q, thr_d;
    logic             spike_q, spike_d;
    logic [3:0]       rcnt_q, rcnt_d;

    logic             leak_event;
    logic             timer_run;
    logic             timer_clear;
    logic [10:0]      product;
    logic [MEM_W-1:0] sum_sat;
    logic [MEM_W-1:0] sum_leak;
    logic [MEM_W-1:0] thr_spike;
    logic [MEM_W-1:0] thr_adapt;

    assign timer_run   = enable && params_ready && (state_q != WAIT_PARAMS);
    assign timer_clear = enable && !params_ready;

    alif_leak_timer u_leak_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (timer_run),
        .clear_i       (timer_clear),
        .leak_cycles_i (leak_cycles),
        .leak_event_o  (leak_event)
    );

    // Datapath: add the weighted input, saturate, then subtract leak, so a
    // coincident input and leak event is compared after both are applied.
    assign product   = 11'(input_current) * 11'(weight_a);
    assign sum_sat   = input_valid ? sat_u8(12'(mem_q) + 12'(product)) : mem_q;
    assign sum_leak  = !leak_event            ? sum_sat :
                       (sum_sat >= leak_rate) ? (sum_sat - leak_rate) : 8'd0;
    assign thr_spike = sat_u8(12'(thr_q) + 12'(THR_INC));

    // Floor enforcement outranks decay so a live raise of threshold_min is
    // honoured immediately rather than racing the decrement.
    always_comb begin
        thr_adapt = thr_q;
        if (thr_q < threshold_min) begin
            thr_adapt = threshold_min;
        end else if (leak_event && (thr_q > threshold_min)) begin
            thr_adapt = thr_q - 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        thr_d   = thr_q;
        rcnt_d  = rcnt_q;
        spike_d = 1'b0;
        if (enable) begin
            if (!params_ready) begin
                state_d = WAIT_PARAMS;
                rcnt_d  = 4'd0;
            end else begin
                case (state_q)
                    WAIT_PARAMS: begin
                        state_d = INTEGRATE;
                        thr_d   = threshold_min;
                    end
                    INTEGRATE: begin
                        if (sum_leak >= thr_q) begin
                            spike_d = 1'b1;
                            mem_d   = 8'd0;
                            thr_d   = thr_spike;
                            rcnt_d  = REFRAC_CYCLES;
                            state_d = REFRACTORY;
                        end else begin
                            mem_d = sum_leak;
                            thr_d = thr_adapt;
                        end
                    end
                    REFRACTORY: begin
                        mem_d = 8'd0;
                        thr_d = thr_adapt;
                        if (rcnt_q <= 4'd1) begin
                            rcnt_d  = 4'd0;
                            state_d = INTEGRATE;
                        end else begin
                            rcnt_d = rcnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_d = WAIT_PARAMS;
                        rcnt_d  = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_PARAMS;
            mem_q   <= 8'd0;
            thr_q   <= 8'd0;
            spike_q <= 1'b0;
            rcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            thr_q   <= thr_d;
            spike_q <= spike_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign spike_out  = spike_q;
    assign membrane   = mem_q;
    assign threshold  = thr_q;
    assign refractory = (state_q == REFRACTORY);

endmodule

// File: tb/tb_alif_neuron_core.sv
// ---------------------------------------------------------------------------
// tb_alif_neuron_core
// Directed testbench for alif_neuron_core with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alif_neuron_core;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       params_ready;
    logic [2:0] weight_a;
    logic [7:0] leak_rate;
    logic [7:0] threshold_min;
    logic [3:0] leak_cycles;
    logic [7:0] input_current;
    logic       input_valid;
    logic       spike_out;
    logic [7:0] membrane;
    logic [7:0] threshold;
    logic       refractory;

    int checks = 0;
    int errors = 0;

    alif_neuron_core #(
        .THR_INC       (8'd10),
        .REFRAC_CYCLES (4'd4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .params_ready  (params_ready),
        .weight_a      (weight_a),
        .leak_rate     (leak_rate),
        .threshold_min (threshold_min),
        .leak_cycles   (leak_cycles),
        .input_current (input_current),
        .input_valid   (input_valid),
        .spike_out     (spike_out),
        .membrane      (membrane),
        .threshold     (threshold),
        .refractory    (refractory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] spike_seen;

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b1;
        params_ready  = 1'b1;
        weight_a      = 3'd2;
        leak_rate     = 8'd2;
        threshold_min = 8'd30;
        leak_cycles   = 4'd2;
        input_current = 8'd0;
        input_valid   = 1'b0;

        // Reset state
        #12;
        chk("rst_membrane", membrane, 8'd0);
        chk("rst_threshold", threshold, 8'd0);
        chk("rst_spike", {7'd0, spike_out}, 8'd0);
        chk("rst_refractory", {7'd0, refractory}, 8'd0);
        rst_n = 1'b1;

        // First edge with params ready loads threshold_min
        step();
        chk("init_threshold", threshold, 8'd30);
        chk("init_membrane", membrane, 8'd0);
        spike_seen = 8'd0;
        for (int i = 0; i < 50; i++) begin
            step();
            spike_seen = spike_seen | {7'd0, spike_out};
        end
        chk("idle_no_spike", spike_seen, 8'd0);
        chk("idle_membrane", membrane, 8'd0);
        chk("idle_threshold", threshold, 8'd30);

        // Integration to spike: 10, 20, spike on 30
        leak_cycles   = 4'd0;
        weight_a      = 3'd2;
        input_current = 8'd5;
        input_valid   = 1'b1;
        step();
        chk("int_mem_1", membrane, 8'd10);
        step();
        chk("int_mem_2", membrane, 8'd20);
        step();
        chk("int_spike", {7'd0, spike_out}, 8'd1);
        chk("int_spike_mem", membrane, 8'd0);
        chk("int_spike_thr", threshold, 8'd40);
        chk("refr_c1", {7'd0, refractory}, 8'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("refr_high", {7'd0, refractory}, 8'd1);
            chk("refr_mem_hold", membrane, 8'd0);
            chk("refr_spike_low", {7'd0, spike_out}, 8'd0);
        end
        step();
        chk("refr_exit", {7'd0, refractory}, 8'd0);
        chk("refr_exit_mem", membrane, 8'd0);
        chk("refr_exit_thr", threshold, 8'd40);

        // Threshold decay 40 -> 30, one per leak event every 2 cycles
        input_valid = 1'b0;
        leak_cycles = 4'd2;
        for (int k = 1; k <= 10; k++) begin
            step();
            step();
            chk("decay_thr", threshold, 8'(40 - k));
        end
        for (int i = 0; i < 4; i++) step();
        chk("decay_floor_hold", threshold, 8'd30);

        // Membrane leak: 10 -> 6 -> 2 -> 0
        leak_cycles   = 4'd0;
        input_current = 8'd5;
        input_valid   = 1'b1;
        step();
        chk("leak_preload", membrane, 8'd10);
        input_valid = 1'b0;
        leak_cycles = 4'd3;
        leak_rate   = 8'd4;
        step();
        step();
        chk("leak_c2", membrane, 8'd10);
        step();
        chk("leak_c3", membrane, 8'd6);
        step(); step(); step();
        chk("leak_c6", membrane, 8'd2);
        step(); step(); step();
        chk("leak_c9", membrane, 8'd0);
        step(); step(); step();
        chk("leak_c12", membrane, 8'd0);
        chk("leak_thr", threshold, 8'd30);

        // Saturation with threshold_min = 255
        leak_rate     = 8'd2;
        leak_cycles   = 4'd0;
        threshold_min = 8'd255;
        step();
        chk("floor_raise", threshold, 8'd255);
        weight_a      = 3'd7;
        input_current = 8'd255;
        input_valid   = 1'b1;
        step();
        chk("sat_spike", {7'd0, spike_out}, 8'd1);
        chk("sat_mem", membrane, 8'd0);
        chk("sat_thr", threshold, 8'd255);
        input_valid = 1'b0;
        step();
        chk("sat_refr_c2", {7'd0, refractory}, 8'd1);

        // Drop params_ready in refractory cycle 2
        params_ready = 1'b0;
        step();
        chk("park_refr", {7'd0, refractory}, 8'd0);
        chk("park_spike", {7'd0, spike_out}, 8'd0);
        chk("park_thr", threshold, 8'd255);
        threshold_min = 8'd30;
        params_ready  = 1'b1;
        step();
        chk("reload_thr", threshold, 8'd30);
        weight_a      = 3'd2;
        input_current = 8'd5;
        input_valid   = 1'b1;
        step();
        chk("reload_mem", membrane, 8'd10);

        // enable low freezes the membrane
        enable = 1'b0;
        step();
        chk("freeze_mem", membrane, 8'd10);
        enable = 1'b1;
        step();
        chk("resume_mem", membrane, 8'd20);

        // Asynchronous reset mid-integration
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mem", membrane, 8'd0);
        chk("arst_thr", threshold, 8'd0);
        chk("arst_spike", {7'd0, spike_out}, 8'd0);
        chk("arst_refr", {7'd0, refractory}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
